// File: rtl/alineador_coma.sv
// Word aligner: finds the K28.5 comma in a 20-bit window of two deserializer words, locks the
// symbol boundary after repeated confirmation and emits framed 10-bit symbols one word late.
module alineador_coma #(
    parameter int          cantidadBits  = 10,
    parameter logic [9:0]  COMA_NEG      = 10'b0011111010,
    parameter logic [9:0]  COMA_POS      = 10'b1100000101,
    parameter int          umbralBloqueo = 3,
    parameter int          umbralPerdida = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enb,
    input  logic [cantidadBits-1:0] entrada,
    input  logic                    entradaValida,
    output logic [cantidadBits-1:0] salida,
    output logic                    salidaValida,
    output logic                    esComa,
    output logic                    bloqueado,
    output logic [3:0]              desplazamiento
);

    typedef enum logic [1:0] {BUSCAR, VERIFICAR, BLOQUEADO} estado_t;

    estado_t     estado, estado_sig;
    logic [9:0]  previo;
    logic [19:0] ventana;
    logic [19:0] desplazada;
    logic [9:0]  candidato;
    logic        coma_bloq;
    logic        hay_coma;
    logic [3:0]  k_coma;
    logic [3:0]  cuenta, cuenta_sig;
    logic [3:0]  errores, errores_sig;
    logic [3:0]  desp_sig;
    logic        aceptada;

    assign aceptada  = enb && entradaValida;
    assign ventana   = {previo, entrada};
    assign bloqueado = (estado == BLOQUEADO);

    // Scan from the highest offset down so the lowest matching offset is the one kept.
    always_comb begin
        hay_coma = 1'b0;
        k_coma   = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (ventana[19-k -: 10] == COMA_NEG || ventana[19-k -: 10] == COMA_POS) begin
                hay_coma = 1'b1;
                k_coma   = 4'(k);
            end
        end
    end

    always_comb begin
        estado_sig  = estado;
        cuenta_sig  = cuenta;
        errores_sig = errores;
        desp_sig    = desplazamiento;
        case (estado)
            BUSCAR: begin
                if (hay_coma) begin
                    desp_sig   = k_coma;
                    cuenta_sig = 4'd1;
                    if (umbralBloqueo == 1) begin
                        estado_sig  = BLOQUEADO;
                        errores_sig = 4'd0;
                    end else begin
                        estado_sig = VERIFICAR;
                    end
                end
            end
            VERIFICAR: begin
                if (hay_coma) begin
                    if (k_coma == desplazamiento) begin
                        cuenta_sig = (cuenta == 4'd15) ? 4'd15 : cuenta + 4'd1;
                        if ({1'b0, cuenta} + 5'd1 == 5'(umbralBloqueo)) begin
                            estado_sig  = BLOQUEADO;
                            errores_sig = 4'd0;
                        end
                    end else begin
                        desp_sig   = k_coma;
                        cuenta_sig = 4'd1;
                    end
                end
            end
            BLOQUEADO: begin
                if (hay_coma) begin
                    if (k_coma == desplazamiento) begin
                        errores_sig = 4'd0;
                    end else begin
                        errores_sig = (errores == 4'd15) ? 4'd15 : errores + 4'd1;
                        if ({1'b0, errores} + 5'd1 == 5'(umbralPerdida)) begin
                            estado_sig  = BUSCAR;
                            cuenta_sig  = 4'd0;
                            errores_sig = 4'd0;
                        end
                    end
                end
            end
            default: estado_sig = BUSCAR;
        endcase
    end

    // The output symbol uses the offset valid after this word, so the locking word is framed too.
    assign desplazada = ventana << desp_sig;
    assign candidato  = desplazada[19:10];
    assign coma_bloq  = (candidato == COMA_NEG) || (candidato == COMA_POS);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado         <= BUSCAR;
            previo         <= 10'd0;
            cuenta         <= 4'd0;
            errores        <= 4'd0;
            desplazamiento <= 4'd0;
            salida         <= '0;
            salidaValida   <= 1'b0;
            esComa         <= 1'b0;
        end else begin
            salidaValida <= 1'b0;
            esComa       <= 1'b0;
            if (aceptada) begin
                previo         <= entrada;
                estado         <= estado_sig;
                cuenta         <= cuenta_sig;
                errores        <= errores_sig;
                desplazamiento <= desp_sig;
                if (estado_sig == BLOQUEADO) begin
                    salida       <= candidato;
                    salidaValida <= 1'b1;
                    esComa       <= coma_bloq;
                end
            end
        end
    end

endmodule

// File: tb/tb_alineador_coma.sv
// Bench for alineador_coma: directed lock/unlock scenarios and a randomized bit stream,
// every cycle compared against a behavioural model of the aligner.
module tb_alineador_coma;

    localparam logic [9:0] NEG  = 10'b0011111010;
    localparam logic [9:0] POS  = 10'b1100000101;
    localparam logic [9:0] DATO = 10'b1001110100;
    localparam int UB = 3;
    localparam int UP = 3;

    logic       clk = 1'b0;
    logic       rst, enb, entradaValida;
    logic [9:0] entrada;
    logic [9:0] salida;
    logic       salidaValida, esComa, bloqueado;
    logic [3:0] desplazamiento;

    always #5 clk = ~clk;

    alineador_coma dut (
        .clk(clk), .rst(rst), .enb(enb), .entrada(entrada), .entradaValida(entradaValida),
        .salida(salida), .salidaValida(salidaValida), .esComa(esComa),
        .bloqueado(bloqueado), .desplazamiento(desplazamiento)
    );

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // model: fase 0 = searching, 1 = verifying, 2 = locked
    logic [9:0] m_prev, m_sal;
    int         m_fase, m_off, m_cnt, m_err;
    bit         m_vld, m_com;

    bit         bits_q[$];
    bit         alt;
    logic [9:0] sal_alzada, ult_sal;
    bit         com_alzada, ult_com, cayo;
    int         n_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] simbolo_en(input logic [19:0] v, input int k);
        logic [19:0] t;
        t = v >> (10 - k);
        return t[9:0];
    endfunction

    function automatic bit es_coma(input logic [9:0] c);
        return (c == NEG) || (c == POS);
    endfunction

    function automatic int primera_coma(input logic [19:0] v);
        for (int k = 0; k < 10; k++)
            if (es_coma(simbolo_en(v, k))) return k;
        return -1;
    endfunction

    task automatic modelo_reset();
        m_prev = 10'd0; m_sal = 10'd0; m_fase = 0; m_off = 0; m_cnt = 0; m_err = 0;
        m_vld = 0; m_com = 0;
    endtask

    task automatic modelo(input bit acept, input logic [9:0] w);
        logic [19:0] v;
        int k;
        m_vld = 0;
        m_com = 0;
        if (!acept) return;
        v = {m_prev, w};
        k = primera_coma(v);
        m_prev = w;
        if (k >= 0) begin
            if (m_fase == 0) begin
                m_off = k; m_cnt = 1;
                m_fase = (UB == 1) ? 2 : 1;
                if (m_fase == 2) m_err = 0;
            end else if (m_fase == 1) begin
                if (k == m_off) begin
                    if (m_cnt + 1 == UB) begin m_fase = 2; m_err = 0; end
                    m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
                end else begin
                    m_off = k; m_cnt = 1;
                end
            end else begin
                if (k == m_off) m_err = 0;
                else if (m_err + 1 == UP) begin m_fase = 0; m_cnt = 0; m_err = 0; end
                else m_err = (m_err >= 15) ? 15 : m_err + 1;
            end
        end
        if (m_fase == 2) begin
            m_sal = simbolo_en(v, m_off);
            m_vld = 1;
            m_com = es_coma(m_sal);
        end
    endtask

    task automatic ciclo(input bit e, input bit v, input logic [9:0] w);
        bit blq_antes;
        @(negedge clk);
        enb = e; entradaValida = v; entrada = w;
        blq_antes = bloqueado;
        @(posedge clk);
        modelo(e && v, w);
        #1;
        chk("salida", 32'(salida), 32'(m_sal));
        chk("salidaValida", 32'(salidaValida), 32'(m_vld));
        chk("esComa", 32'(esComa), 32'(m_com));
        chk("bloqueado", 32'(bloqueado), 32'(m_fase == 2));
        chk("desplazamiento", 32'(desplazamiento), 32'(m_off));
        if (!blq_antes && bloqueado) begin sal_alzada = salida; com_alzada = esComa; end
        if (blq_antes && !bloqueado) cayo = 1;
        if (salidaValida) begin n_vld++; ult_sal = salida; ult_com = esComa; end
    endtask

    task automatic reinicio();
        @(negedge clk);
        rst = 1'b1; enb = 1'b0; entradaValida = 1'b1; entrada = 10'($urandom);
        @(posedge clk);
        modelo_reset();
        #1;
        chk("rst salida", 32'(salida), 32'd0);
        chk("rst salidaValida", 32'(salidaValida), 32'd0);
        chk("rst esComa", 32'(esComa), 32'd0);
        chk("rst bloqueado", 32'(bloqueado), 32'd0);
        chk("rst desplazamiento", 32'(desplazamiento), 32'd0);
        rst = 1'b0; entradaValida = 1'b0; enb = 1'b1;
        bits_q.delete();
        alt = 1'b1;
    endtask

    task automatic poner_sim(input logic [9:0] s);
        for (int i = 9; i >= 0; i--) bits_q.push_back(s[i]);
    endtask

    // Alternating filler bits never form the 5-bit run a comma needs.
    task automatic poner_bits(input int n);
        for (int i = 0; i < n; i++) begin bits_q.push_back(alt); alt = ~alt; end
    endtask

    task automatic poner_aleat(input int n);
        for (int i = 0; i < n; i++) bits_q.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic vaciar(input int hueco, input bit aleat);
        logic [9:0] w;
        int g;
        while (bits_q.size() >= 10) begin
            for (int i = 9; i >= 0; i--) w[i] = bits_q.pop_front();
            if (aleat && $urandom_range(0, 7) == 0) ciclo(1'b0, 1'b1, 10'($urandom));
            ciclo(1'b1, 1'b1, w);
            g = aleat ? int'($urandom_range(0, 3)) : hueco;
            repeat (g) ciclo(1'b1, 1'b0, 10'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; enb = 1'b0; entradaValida = 1'b0; entrada = 10'd0;
        alt = 1'b1; cayo = 0; n_vld = 0; sal_alzada = 10'd0; com_alzada = 0;
        ult_sal = 10'd0; ult_com = 0;
        reinicio();

        // three commas at offset 4 lock on the third
        poner_bits(4);
        repeat (3) poner_sim(NEG);
        poner_sim(DATO);
        vaciar(2, 0);
        chk("lock4 bloqueado", 32'(bloqueado), 32'd1);
        chk("lock4 desplazamiento", 32'(desplazamiento), 32'd4);
        chk("lock4 salida at lock", 32'(sal_alzada), 32'(NEG));
        chk("lock4 esComa at lock", 32'(com_alzada), 32'd1);

        // aligned data while locked: one valid pulse per strobe
        n_vld = 0;
        repeat (2) poner_sim(DATO);
        vaciar(2, 0);
        chk("data salida", 32'(ult_sal), 32'(DATO));
        chk("data esComa", 32'(ult_com), 32'd0);
        chk("data valid pulses", 32'(n_vld), 32'd2);

        // slip to offset 7: three foreign commas drop lock, three more relock
        cayo = 0;
        poner_bits(3);
        repeat (3) poner_sim(NEG);
        poner_sim(DATO);
        vaciar(2, 0);
        chk("loss cayo", 32'(cayo), 32'd1);
        chk("loss bloqueado", 32'(bloqueado), 32'd0);
        chk("loss desplazamiento kept", 32'(desplazamiento), 32'd4);
        sal_alzada = 10'd0;
        repeat (3) poner_sim(NEG);
        poner_sim(DATO);
        vaciar(1, 0);
        chk("relock bloqueado", 32'(bloqueado), 32'd1);
        chk("relock desplazamiento", 32'(desplazamiento), 32'd7);
        chk("relock salida", 32'(sal_alzada), 32'(NEG));

        // 2 foreign, 1 locked, 2 foreign: errors cleared, lock retained
        cayo = 0;
        poner_bits(3); repeat (2) poner_sim(NEG);
        poner_bits(7); poner_sim(NEG);
        poner_bits(3); repeat (2) poner_sim(NEG);
        poner_bits(7); repeat (2) poner_sim(DATO);
        vaciar(1, 0);
        chk("retain cayo", 32'(cayo), 32'd0);
        chk("retain bloqueado", 32'(bloqueado), 32'd1);
        chk("retain desplazamiento", 32'(desplazamiento), 32'd7);
        chk("retain salida", 32'(ult_sal), 32'(DATO));

        // strobe with enb low is dropped; outputs hold, valid stays low
        ciclo(1'b0, 1'b1, 10'($urandom));
        chk("enb0 salidaValida", 32'(salidaValida), 32'd0);
        chk("enb0 bloqueado", 32'(bloqueado), 32'd1);
        poner_sim(DATO);
        vaciar(1, 0);

        // reset mid-lock, then 2 commas at offset 2 and 1 at offset 5
        reinicio();
        poner_bits(2);
        repeat (2) poner_sim(NEG);
        poner_bits(3);
        poner_sim(NEG);
        poner_sim(DATO);
        vaciar(1, 0);
        chk("verify desplazamiento", 32'(desplazamiento), 32'd5);
        chk("verify bloqueado", 32'(bloqueado), 32'd0);
        poner_sim(NEG); poner_sim(DATO);
        vaciar(1, 0);
        chk("verify2 bloqueado", 32'(bloqueado), 32'd0);
        poner_sim(NEG); poner_sim(DATO);
        vaciar(1, 0);
        chk("verify3 bloqueado", 32'(bloqueado), 32'd1);
        chk("verify3 desplazamiento", 32'(desplazamiento), 32'd5);

        // randomized stream with slips, gaps, back-to-back strobes and dropped words
        reinicio();
        for (int s = 0; s < 400; s++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 3) poner_sim(NEG);
            else if (r < 5) poner_sim(POS);
            else poner_sim(10'($urandom));
            if ($urandom_range(0, 11) == 0) poner_aleat(int'($urandom_range(1, 9)));
            if (s == 250) begin vaciar(0, 1); reinicio(); end
            vaciar(0, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
